fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage: owns the PC, issues word requests to instruction memory and buffers returned words in an in-order FIFO. It presents {pc, instr} to the decode stage over a valid/ready handshake. id_instr is the instr_code source for the immediate generator and decoder. Redirects from execute (branch/jump) flush everything fetched down the wrong path.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
FIFO_DEPTH, 4, fetch buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 2, maximum accepted-but-unanswered imem requests

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  word-aligned fetch address (= pc)
imem_rsp_valid  in  1  response word valid; in order, >=1 cycle after acceptance
imem_rsp_data  in  32  instruction word
redirect_valid  in  1  redirect PC (one-cycle pulse)
redirect_pc  in  32  new fetch target
id_valid  out  1  decode entry valid
id_ready  in  1  decode accepts entry
id_instr  out  32  instruction word to decode/ImmGen
id_pc  out  32  PC of id_instr
misalign_err  out  1  sticky: a redirect target had pc[1:0]!=0

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, rsp_pc=RESET_PC, inflight=0, discard=0, FIFO empty, misalign_err=0. Outputs during reset: imem_req_valid=0, imem_req_addr=RESET_PC, id_valid=0, id_instr=0, id_pc=0.
- Credit rule: imem_req_valid = !redirect_valid && inflight<MAX_OUTSTANDING && (inflight+discard+count)<FIFO_DEPTH. Purely registered inputs except redirect_valid. Once asserted without redirect, valid and addr stay stable until accepted.
- Accept (valid&&ready): pc+=4 (32-bit wrap, 32'hFFFF_FFFC -> 0), inflight+=1.
- Response: if discard>0, drop the word and decrement discard. Else push {rsp_pc, data}, rsp_pc+=4, inflight-=1. rsp_valid with inflight==0 && discard==0 is ignored (protocol violation).
- Push into a full FIFO is impossible by the credit rule. Same-cycle push and pop are both performed and count is unchanged.
- Output: id_valid = count!=0. id_instr/id_pc = head entry, driven from registers with zero combinational path from id_ready. Pop on id_valid&&id_ready. Fall-through latency: response in cycle N -> id_valid in N+1.
- Redirect (highest priority): pc and rsp_pc <= {redirect_pc[31:2],2'b00}. FIFO flushed (count=0, any same-cycle pop ignored). discard += inflight, minus 1 if a non-discarded response arrives in the same cycle (that word is dropped). inflight=0. No request is issued in the redirect cycle. If redirect_pc[1:0]!=0, misalign_err is set and stays set until reset.
- Redirect while discard>0: accumulate. Back-to-back redirects: the last one wins.
- Widths: inflight/discard counters are clog2(MAX_OUTSTANDING*2)+1 bits and must never underflow (assertion).

Decomposition:
- Shared package: RESET_PC default, XLEN=32, ILEN=32, fetch_entry_t {pc, instr}, and the opcode constants used by decode/ImmGen (LOAD 7'b0000011, OP_IMM 7'b0010011, STORE 7'b0100011, AUIPC 7'b0010111).
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with flush, push, pop, count, and head output.

Test Plan:
- Reset, ready=1, rsp latency 1, id_ready=1 -> requests at 0x0,0x4,0x8... After the first response, id_pc advances by 4 every cycle, with id_instr matching memory.
- id_ready=0 for 10 cycles -> FIFO fills to 4, imem_req_valid drops once inflight+count=4, no words are lost, and they are delivered in order 0x0..0xC after release.
- Two requests in flight, redirect to 0x100 -> both late responses are dropped. The next id_pc is 0x100 and no stale pc appears on id.
- Redirect in the same cycle as a response and as an id handshake -> FIFO empty the next cycle, that response is dropped, and the next request address is the target.
- Redirect to 0x102 -> fetch resumes at 0x100 and misalign_err=1, which persists until rst_n is asserted.
- rst_n asserted mid-stream with 2 in flight -> outputs go to their reset values immediately (async). After release, fetch restarts at RESET_PC and the memory model is also reset.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch/decode types and constants: machine widths, the fetch buffer entry
// and the opcodes that decode and the immediate generator switch on.
package fetch_stage_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

  // Opcodes whose immediate is formed from instr[31:20] or the S-type split.
  function automatic logic has_i_or_s_imm(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_OP_IMM) || (opc == OPC_STORE);
  endfunction

  function automatic logic has_u_imm(input logic [6:0] opc);
    return opc == OPC_AUIPC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect and decode-side handshakes.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            id_valid;
  logic            id_ready;
  logic [ILEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic            misalign_err;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, misalign_err,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, misalign_err,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_stage_fifo.sv
// In-order fetch buffer; the head entry comes straight from storage registers so
// the decode-side outputs never depend combinationally on the pop request.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int NW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [NW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + NW'(push) - NW'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word requests, buffers
// in-order responses and drops words fetched down a redirected-away path.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = DEFAULT_RESET_PC,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master bus
);

  localparam int CW = $clog2(MAX_OUTSTANDING * 2) + 1;
  localparam int NW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = ((CW > NW) ? CW : NW) + 2;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [NW-1:0]   count;
  logic [OW-1:0]   occupancy;
  logic            misalign_q;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            req_fire;
  logic            rsp_take;
  logic            rsp_drop;
  logic            rsp_push;
  logic            pop;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign redirect  = bus.redirect_valid;
  assign target    = align_pc(bus.redirect_pc);
  assign occupancy = OW'(inflight) + OW'(discard) + OW'(count);

  // Every word that can still come back owns a buffer slot, so a push never meets a full FIFO.
  assign bus.imem_req_valid = rst_n && !redirect
                              && (inflight < CW'(MAX_OUTSTANDING))
                              && (occupancy < OW'(FIFO_DEPTH));
  assign bus.imem_req_addr  = pc;

  assign req_fire   = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_take   = bus.imem_rsp_valid && ((inflight != '0) || (discard != '0));
  assign rsp_drop   = rsp_take && (discard != '0);
  assign rsp_push   = rsp_take && (discard == '0) && !redirect;
  assign pop        = bus.id_valid && bus.id_ready && !redirect;
  assign push_entry = '{pc: rsp_pc, instr: bus.imem_rsp_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      rsp_pc     <= RESET_PC;
      inflight   <= '0;
      discard    <= '0;
      misalign_q <= 1'b0;
    end else if (redirect) begin
      pc       <= target;
      rsp_pc   <= target;
      inflight <= '0;
      // A word arriving now is wrong-path either way, so it consumes one of the owed drops.
      discard  <= discard + inflight - CW'(rsp_take);
      if (bus.redirect_pc[1:0] != 2'b00) misalign_q <= 1'b1;
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      if (rsp_push) rsp_pc <= rsp_pc + XLEN'(4);
      inflight <= inflight + CW'(req_fire) - CW'(rsp_take && !rsp_drop);
      discard  <= discard - CW'(rsp_drop);
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .push      (rsp_push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign bus.id_valid     = (count != '0);
  assign bus.id_instr     = head.instr;
  assign bus.id_pc        = head.pc;
  assign bus.misalign_err = misalign_q;

  a_counters_sane: assert property (@(posedge clk) disable iff (!rst_n)
    (inflight <= CW'(MAX_OUTSTANDING)) && (occupancy <= OW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a queued memory model answers requests and a
// scoreboard monitor checks every decode handshake against expected {pc, instr}.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           tests = 0;
  int           fails = 0;
  int           delivered = 0;
  logic         mem_hold = 1'b0;
  logic [31:0]  mem_q [$];
  fetch_entry_t sb_exp [$];
  fetch_entry_t mon_exp;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a << 10) ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic expectPc(input logic [31:0] a);
    fetch_entry_t e;
    e.pc    = a;
    e.instr = mem_word(a);
    sb_exp.push_back(e);
  endtask

  task automatic applyStimulus(input logic rstn, input logic rdir, input logic [31:0] rpc,
                               input logic req_rdy, input logic hold, input logic dec_rdy);
    @(negedge clk);
    rst_n              = rstn;
    bus.redirect_valid = rdir;
    bus.redirect_pc    = rpc;
    bus.imem_req_ready = req_rdy;
    mem_hold           = hold;
    bus.id_ready       = dec_rdy;
    #4;
  endtask

  task automatic checkDrained(input string name, input int want);
    checkOutput({name, "_delivered"}, 32'(delivered), 32'(want));
    checkOutput({name, "_sb_left"}, 32'(sb_exp.size()), 32'd0);
    sb_exp.delete();
  endtask

  // Memory model: in-order, one cycle minimum latency, can be held to keep words in flight.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        mem_q.delete();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end else begin
        if (!mem_hold && mem_q.size() > 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = mem_word(mem_q.pop_front());
        end else begin
          bus.imem_rsp_valid = 1'b0;
          bus.imem_rsp_data  = '0;
        end
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready) mem_q.push_back(bus.imem_req_addr);
      end
    end
  end

  // Scoreboard monitor; a redirect cycle's handshake is flushed, not delivered.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
        delivered++;
        if (sb_exp.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_entry: got pc %h instr %h, expected no entry", bus.id_pc, bus.id_instr);
        end else begin
          mon_exp = sb_exp.pop_front();
          checkOutput("id_pc", bus.id_pc, mon_exp.pc);
          checkOutput("id_instr", bus.id_instr, mon_exp.instr);
        end
      end
    end
  end

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b0;

    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    checkBit("rst_req_valid", bus.imem_req_valid, 1'b0);
    checkOutput("rst_req_addr", bus.imem_req_addr, 32'h0);
    checkBit("rst_id_valid", bus.id_valid, 1'b0);
    checkOutput("rst_id_instr", bus.id_instr, 32'h0);
    checkOutput("rst_id_pc", bus.id_pc, 32'h0);
    checkBit("rst_misalign", bus.misalign_err, 1'b0);

    // Streaming: one word per cycle once the pipe fills.
    for (int i = 0; i < 8; i++) expectPc(32'(i * 4));
    delivered = 0;
    repeat (8) applyStimulus(1, 0, 0, 1, 0, 1);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("stream_throughput", 32'(delivered), 32'd8);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 1);
    checkDrained("stream", 8);

    // Decode stalled: buffer fills and requests stop at the credit limit.
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) expectPc(32'(i * 4));
    delivered = 0;
    repeat (4) applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkBit("fill_req_stops", bus.imem_req_valid, 1'b0);
    repeat (2) applyStimulus(1, 0, 0, 1, 0, 0);
    checkBit("fill_req_held", bus.imem_req_valid, 1'b0);
    checkBit("fill_id_valid", bus.id_valid, 1'b1);
    checkOutput("fill_next_addr", bus.imem_req_addr, 32'h10);
    repeat (3) applyStimulus(1, 0, 0, 1, 0, 0);
    repeat (8) applyStimulus(1, 0, 0, 0, 0, 1);
    checkDrained("fill", 4);

    // Redirect with two requests outstanding: both late words are dropped.
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    delivered = 0;
    repeat (2) applyStimulus(1, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    checkBit("inflight_cap", bus.imem_req_valid, 1'b0);
    applyStimulus(1, 1, 32'h100, 1, 1, 0);
    checkBit("redirect_no_req", bus.imem_req_valid, 1'b0);
    expectPc(32'h100);
    expectPc(32'h104);
    applyStimulus(1, 0, 0, 1, 0, 1);
    checkOutput("redirect_addr", bus.imem_req_addr, 32'h100);
    checkBit("redirect_req_valid", bus.imem_req_valid, 1'b1);
    applyStimulus(1, 0, 0, 1, 0, 1);
    repeat (5) applyStimulus(1, 0, 0, 0, 0, 1);
    checkDrained("late_drop", 2);

    // Redirect coinciding with a response and a decode handshake.
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    delivered = 0;
    repeat (2) applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 1, 32'h200, 1, 0, 1);
    checkBit("coinc_id_valid_before", bus.id_valid, 1'b1);
    checkBit("coinc_no_req", bus.imem_req_valid, 1'b0);
    expectPc(32'h200);
    applyStimulus(1, 0, 0, 1, 0, 1);
    checkBit("coinc_flushed", bus.id_valid, 1'b0);
    checkOutput("coinc_target_addr", bus.imem_req_addr, 32'h200);
    checkBit("coinc_req_valid", bus.imem_req_valid, 1'b1);
    repeat (5) applyStimulus(1, 0, 0, 0, 0, 1);
    checkDrained("coinc", 1);
    checkBit("aligned_no_err", bus.misalign_err, 1'b0);

    // Misaligned target: fetch resumes word-aligned, error is sticky.
    delivered = 0;
    applyStimulus(1, 1, 32'h102, 0, 0, 1);
    expectPc(32'h100);
    applyStimulus(1, 0, 0, 1, 0, 1);
    checkBit("misalign_set", bus.misalign_err, 1'b1);
    checkOutput("misalign_addr", bus.imem_req_addr, 32'h100);
    repeat (5) applyStimulus(1, 0, 0, 0, 0, 1);
    checkBit("misalign_sticky", bus.misalign_err, 1'b1);
    checkDrained("misalign", 1);

    // Asynchronous reset with two words outstanding and one buffered.
    repeat (2) applyStimulus(1, 0, 0, 1, 0, 0);
    repeat (2) applyStimulus(1, 0, 0, 1, 1, 0);
    checkBit("pre_rst_id_valid", bus.id_valid, 1'b1);
    checkOutput("pre_rst_id_pc", bus.id_pc, 32'h104);
    #1 rst_n = 1'b0;
    #1;
    checkBit("async_req_valid", bus.imem_req_valid, 1'b0);
    checkOutput("async_req_addr", bus.imem_req_addr, 32'h0);
    checkBit("async_id_valid", bus.id_valid, 1'b0);
    checkOutput("async_id_instr", bus.id_instr, 32'h0);
    checkOutput("async_id_pc", bus.id_pc, 32'h0);
    checkBit("async_misalign", bus.misalign_err, 1'b0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    delivered = 0;
    expectPc(32'h0);
    expectPc(32'h4);
    repeat (2) applyStimulus(1, 0, 0, 1, 0, 1);
    repeat (5) applyStimulus(1, 0, 0, 0, 0, 1);
    checkDrained("restart", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
